// File: rtl/mem_stage_pkg.sv
// Shared types, funct3 codes and lane helpers for the MEM-stage load/store unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
// Contents: lsu_state_e, F3_* width codes, byte-enable / alignment / store-lane functions.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] alone encodes the access size: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Clear the low offset bits a naturally aligned access of this size cannot have.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  // Store data is replicated across lanes; byte enables pick the lane written.
  function automatic logic [31:0] st_lanes(input logic [1:0] sz, input logic [31:0] data);
    case (sz)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_ld_align.sv
// Load-data aligner: selects byte/half/word from a read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
// Ports: rdata_i read word, funct3_i RV32I load width code, addr_i byte offset, result_o extended value.
module ld_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Codes 011/110/111 fall through to the full word.
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'b0, byte_sel};
      F3_LHU:  result_o = {16'b0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues dmem req/gnt/rvalid accesses, aligns load data.
// Latency: store 3 cycles, load 4 cycles with zero memory wait; +1 per memory wait cycle.
// Backpressure: stall_o holds the pipeline from issue until DONE; watchdog aborts after WAIT_MAX cycles.
// Ports: clk_i/rst_i (sync, active-high); valid_i/is_load_i/is_store_i/funct3_i/addr_i/st_data_i from EX/MEM;
//        dmem_* request/response channel; ld_data_o/err_o valid in DONE; stall_o combinational.
// Optional: define MEM_MISALIGN_TRAP_EN to abort misaligned half/word accesses with err_o instead of
//           silently forcing natural alignment.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       st_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       ld_data_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam bit WD_EN = (WAIT_MAX != 0);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       ld_q, ld_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_op;
  logic              misalign;
  logic [1:0]        off_eff;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wd_hit;
  logic [31:0]       ld_aligned;

  ld_align u_ld_align (
    .rdata_i  (dmem_rdata_i),
    .funct3_i (f3_q),
    .addr_i   (off_q),
    .result_o (ld_aligned)
  );

  always_comb begin
    mem_op  = valid_i & (is_load_i | is_store_i);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = misaligned(funct3_i[1:0], addr_i[1:0]);
    off_eff  = addr_i[1:0];
`else
    misalign = 1'b0;
    off_eff  = align_off(funct3_i[1:0], addr_i[1:0]);
`endif
    cnt_inc = cnt_q + CNT_W'(1);
    // Counter holds cycles already spent in this state; abort on the WAIT_MAX-th.
    wd_hit  = WD_EN && (cnt_inc == CNT_W'(WAIT_MAX));

    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall_o = 1'b0;

    case (state_q)
      IDLE: begin
        stall_o = mem_op;
        cnt_d   = '0;
        if (mem_op) begin
          addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          be_d    = byte_en(funct3_i[1:0], off_eff);
          wdata_d = st_lanes(funct3_i[1:0], st_data_i);
          off_d   = off_eff;
          f3_d    = funct3_i;
          if (misalign) begin
            state_d = DONE;
            err_d   = 1'b1;
            ld_d    = '0;
            req_d   = 1'b0;
            we_d    = 1'b0;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store_i;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          // we_q still marks the in-flight access as a store here.
          state_d = we_q ? DONE : WAIT;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
        end else if (wd_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          ld_d    = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        // A response arriving on the final allowed cycle still wins over the abort.
        if (dmem_rvalid_i) begin
          state_d = DONE;
          ld_d    = ld_aligned;
          cnt_d   = '0;
        end else if (wd_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          ld_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign ld_data_o    = ld_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int WMAX = 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, is_load_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, st_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] ld_data_o;
  logic        stall_o, err_o;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .WAIT_MAX(WMAX)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .st_data_i(st_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .ld_data_o(ld_data_o),
    .stall_o(stall_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          obs_cycles, obs_req;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err, obs_stable, obs_timeout, obs_req_done;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return ((addr % 4) / sz) * sz;
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int v = ((1 << size_of(f3)) - 1) << eff_off(f3, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (size_of(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] w = rd >> (8 * eff_off(f3, addr));
    logic [31:0] b = w & 32'hFF;
    logic [31:0] h = w & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = '0;
    addr_i = '0; st_data_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = $urandom;
  endtask

  // Presents one instruction and acts as the memory until stall_o drops (DONE cycle).
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int gnt_dly, input int rv_dly);
    int   req_seen = 0;
    int   wait_seen = 0;
    logic pend = 1'b0;
    logic in_wait = 1'b0;
    logic done = 1'b0;
    obs_cycles = 0; obs_req = 0; obs_stable = 1'b1; obs_timeout = 1'b0;
    obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
    obs_ld = '0; obs_err = 1'b0; obs_req_done = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = !st; is_store_i = st; funct3_i = f3;
    addr_i = addr; st_data_i = sd;
    for (int c = 0; c < 40; c++) begin
      if (pend) begin in_wait = 1'b1; pend = 1'b0; end
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      if (in_wait) begin
        if (wait_seen == rv_dly) begin
          dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; in_wait = 1'b0;
        end
        wait_seen++;
      end
      if (dmem_req_o === 1'b1) begin
        if (req_seen == 0) begin
          obs_addr = dmem_addr_o; obs_be = dmem_be_o; obs_wdata = dmem_wdata_o; obs_we = dmem_we_o;
        end else if (dmem_addr_o !== obs_addr || dmem_be_o !== obs_be ||
                     dmem_wdata_o !== obs_wdata || dmem_we_o !== obs_we) begin
          obs_stable = 1'b0;
        end
        if (req_seen == gnt_dly) begin dmem_gnt_i = 1'b1; pend = !st; end
        req_seen++;
      end
      #1;
      if (stall_o === 1'b0) begin
        obs_cycles = c + 1; obs_ld = ld_data_o; obs_err = err_o; obs_req_done = dmem_req_o;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    obs_req = req_seen;
    obs_timeout = !done;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dmem_req_o, dmem_we_o, err_o, stall_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {dmem_req_o, dmem_we_o, err_o, stall_o});
    end
    n_tests++;
    if ({dmem_addr_o, dmem_be_o, dmem_wdata_o, ld_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %h be %b wdata %h ld %h expected all 0",
                         dmem_addr_o, dmem_be_o, dmem_wdata_o, ld_data_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_bubble();
    @(posedge clk); #1;
    idle_inputs(); is_load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        n_fail++; $display("FAIL bubble: got stall %b req %b expected 0 0", stall_o, dmem_req_o);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_store_word();
    run_access(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0);
    n_tests++;
    if (obs_cycles !== 3 || obs_req !== 1 || obs_timeout) begin
      n_fail++; $display("FAIL sw_latency: got cycles %0d req %0d expected 3 1", obs_cycles, obs_req);
    end
    n_tests++;
    if (obs_addr !== 32'h104 || obs_be !== 4'b1111 || obs_wdata !== 32'hDEAD_BEEF || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL sw_bus: got addr %h be %b wdata %h we %b expected 104 1111 deadbeef 1",
                         obs_addr, obs_be, obs_wdata, obs_we);
    end
    n_tests++;
    if (obs_err !== 1'b0) begin
      n_fail++; $display("FAIL sw_err: got %b expected 0", obs_err);
    end
  endtask

  task automatic test_byte_load();
    run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
    n_tests++;
    if (obs_ld !== 32'hFFFF_FF80 || obs_cycles !== 4) begin
      n_fail++; $display("FAIL lb: got ld %h cycles %0d expected ffffff80 4", obs_ld, obs_cycles);
    end
    run_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0, 0);
    n_tests++;
    if (obs_ld !== 32'h0000_0080 || obs_cycles !== 4) begin
      n_fail++; $display("FAIL lbu: got ld %h cycles %0d expected 00000080 4", obs_ld, obs_cycles);
    end
    n_tests++;
    if (obs_addr !== 32'h200 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
      n_fail++; $display("FAIL lbu_bus: got addr %h be %b we %b expected 200 1000 0", obs_addr, obs_be, obs_we);
    end
  endtask

  task automatic test_half_store_wait();
    run_access(1'b1, 3'b001, 32'h0A, 32'h0000_ABCD, 32'h0, 3, 0);
    n_tests++;
    if (obs_cycles !== 6 || obs_req !== 4 || !obs_stable) begin
      n_fail++; $display("FAIL sh_wait: got cycles %0d req %0d stable %b expected 6 4 1",
                         obs_cycles, obs_req, obs_stable);
    end
    n_tests++;
    if (obs_addr !== 32'h08 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD) begin
      n_fail++; $display("FAIL sh_bus: got addr %h be %b wdata %h expected 08 1100 abcdabcd",
                         obs_addr, obs_be, obs_wdata);
    end
  endtask

  task automatic test_watchdog();
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 0, 1000);
    n_tests++;
    if (obs_cycles !== 3 + WMAX || obs_err !== 1'b1 || obs_ld !== 32'h0) begin
      n_fail++; $display("FAIL wd_wait: got cycles %0d err %b ld %h expected %0d 1 0",
                         obs_cycles, obs_err, obs_ld, 3 + WMAX);
    end
    @(posedge clk); #1;
    idle_inputs(); dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 32'h7F7F_7F7F;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
    #1;
    n_tests++;
    if (ld_data_o !== 32'h0 || err_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_late_rvalid: got ld %h err %b stall %b req %b expected 0 0 0 0",
                         ld_data_o, err_o, stall_o, dmem_req_o);
    end
    run_access(1'b1, 3'b010, 32'h310, 32'h5, 32'h0, 1000, 0);
    n_tests++;
    if (obs_cycles !== 2 + WMAX || obs_err !== 1'b1 || obs_req_done !== 1'b0 || obs_req !== WMAX) begin
      n_fail++; $display("FAIL wd_req: got cycles %0d err %b req_done %b reqs %0d expected %0d 1 0 %0d",
                         obs_cycles, obs_err, obs_req_done, obs_req, 2 + WMAX, WMAX);
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    idle_inputs(); valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
    @(posedge clk); #1;
    dmem_gnt_i = dmem_req_o;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || ld_data_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: got req %b stall %b ld %h expected 0 0 0", dmem_req_o, stall_o, ld_data_o);
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    #1;
    n_tests++;
    if (ld_data_o !== 32'h0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale_rvalid: got ld %h stall %b expected 0 0", ld_data_o, stall_o);
    end
  endtask

  task automatic test_misalign();
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    n_tests++;
    if (obs_req !== 0 || obs_err !== 1'b1 || obs_cycles !== 2 || obs_ld !== 32'h0) begin
      n_fail++; $display("FAIL misalign_trap: got req %0d err %b cycles %0d ld %h expected 0 1 2 0",
                         obs_req, obs_err, obs_cycles, obs_ld);
    end
`else
    n_tests++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_err !== 1'b0 || obs_ld !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL misalign_force: got addr %h be %b err %b ld %h expected 100 1111 0 cafef00d",
                         obs_addr, obs_be, obs_err, obs_ld);
    end
`endif
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] ld_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 60; i++) begin
      logic        st   = $urandom_range(0, 1) == 1;
      logic [2:0]  f3   = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 7)];
      logic [31:0] addr = $urandom;
      logic [31:0] sd   = $urandom;
      logic [31:0] rd   = $urandom;
      int          gd   = $urandom_range(0, 2);
      int          rv   = $urandom_range(0, 2);
      logic        trap = TRAP && is_mis(f3, addr);
      int          exp_cyc;
      run_access(st, f3, addr, sd, rd, gd, rv);
      exp_cyc = trap ? 2 : (st ? gd + 3 : gd + rv + 4);
      n_tests++;
      if (obs_cycles !== exp_cyc || obs_err !== trap || obs_timeout) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: got cycles %0d err %b expected %0d %b",
                           i, obs_cycles, obs_err, exp_cyc, trap);
      end
      if (trap) begin
        n_tests++;
        if (obs_req !== 0 || obs_ld !== 32'h0) begin
          n_fail++; $display("FAIL rnd_trap[%0d]: got req %0d ld %h expected 0 0", i, obs_req, obs_ld);
        end
      end else begin
        n_tests++;
        if (obs_addr !== (addr & ~32'h3) || obs_be !== model_be(f3, addr) || obs_we !== st ||
            !obs_stable || obs_req !== gd + 1) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: got addr %h be %b we %b stable %b reqs %0d expected %h %b %b 1 %0d",
                             i, obs_addr, obs_be, obs_we, obs_stable, obs_req,
                             addr & ~32'h3, model_be(f3, addr), st, gd + 1);
        end
        if (st) begin
          n_tests++;
          if (obs_wdata !== model_wdata(f3, sd)) begin
            n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, obs_wdata, model_wdata(f3, sd));
          end
        end else begin
          n_tests++;
          if (obs_ld !== model_load(f3, addr, rd)) begin
            n_fail++; $display("FAIL rnd_load[%0d]: f3 %0d addr %h got %h expected %h",
                               i, f3, addr, obs_ld, model_load(f3, addr, rd));
          end
        end
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_bubble();
    test_store_word();
    test_byte_load();
    test_half_store_wait();
    test_watchdog();
    test_reset_mid_access();
    test_misalign();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues loads and stores to data memory over a req/gnt/rvalid handshake.
- Aligns and sign-extends load data. Drives stall_o, which gates upstream pipeline registers and the MEM/WB register enable until the access completes.
- Non-memory instructions pass through with zero stall.

Parameters:
- ADDR_W, 32, data-memory address width; addr_i[ADDR_W-1:0] used, dmem_addr_o word-aligned.
- WAIT_MAX, 255, cycles allowed in REQ or WAIT before the watchdog aborts the access with err_o; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  instruction in MEM is valid (not bubble/flushed)
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- funct3_i  in  3  RV32I load/store width code
- addr_i  in  ADDR_W  effective byte address from ALU
- st_data_i  in  32  store source register value
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_W  word address, low 2 bits zero
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word
- ld_data_o  out  32  aligned/extended load result, valid in DONE
- stall_o  out  1  hold pipeline this cycle
- err_o  out  1  one-cycle pulse in DONE when access aborted (watchdog or misalign)

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset values:
  - state = IDLE.
  - All registered outputs 0: ld_data_o = 0, err_o = 0, dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_be_o = 0, dmem_wdata_o = 0.
  - Watchdog counter = 0.
- IDLE:
  - mem_op = valid_i & (is_load_i | is_store_i).
  - stall_o = mem_op (combinational). If mem_op, latch addr, funct3, is_store, be, wdata and go to REQ. Otherwise stay in IDLE, stall_o = 0.
- REQ: dmem_req_o = 1, address/be/wdata/we stable, stall_o = 1.
  - On dmem_gnt_i: a store goes to DONE; a load goes to WAIT.
- WAIT: stall_o = 1.
  - On dmem_rvalid_i: capture the aligned/extended result into ld_data_o and go to DONE.
  - rvalid is never sampled in the same cycle as gnt.
- DONE: stall_o = 0 for exactly one cycle, so the pipeline advances and MEM/WB captures ld_data_o. Next state is IDLE.
- Latency: store = 3 cycles with gnt in the first REQ cycle; load = 4 cycles with rvalid the cycle after gnt. Each extra memory wait cycle adds 1.
- Load extract by funct3:
  - 000 LB sign-extends byte addr[1:0].
  - 001 LH sign-extends half addr[1].
  - 010 LW takes the full word.
  - 100 LBU and 101 LHU zero-extend.
  - 011, 110, 111 are treated as LW.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; data byte replicated to all 4 lanes.
  - SH: be = 4'b0011 << (2*addr[1]); half replicated.
  - SW: be = 4'b1111.
- Watchdog: the counter increments each cycle in REQ/WAIT and clears on state entry. If it reaches WAIT_MAX, go to DONE with err_o = 1 and ld_data_o = 0, and drop dmem_req_o.
- A late dmem_rvalid_i or dmem_gnt_i arriving in IDLE or DONE is ignored.
- rst_i asserted mid-access: next cycle state = IDLE and dmem_req_o = 0. Any outstanding response is discarded.
- valid_i = 0 with is_load_i = 1 (bubble): no access, no stall.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned LH/LHU/SH (addr[0] = 1) or LW/SW (addr[1:0] != 0) issues no request. IDLE goes directly to DONE with err_o = 1, ld_data_o = 0 and no memory write; stall is 1 cycle.
- Undefined: low address bits are forced to natural alignment (half clears addr[0], word clears addr[1:0]) and the access proceeds normally; err_o is raised only by the watchdog.

Decomposition:
- Package mem_stage_pkg holds:
  - the lsu_state_e enum (IDLE, REQ, WAIT, DONE);
  - localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW;
  - a function computing be from funct3 and addr[1:0].
- One combinational sub-module, ld_align: inputs rdata[31:0], funct3, addr[1:0]; output 32-bit result. It is reusable by a future cache.

Test Plan:
- Store path: SW addr 0x104, data 0xDEADBEEF, gnt in first REQ cycle -> req/we for one cycle, addr 0x104, be 1111, stall 1,1,0 over 3 cycles.
- Byte load: LB addr 0x203, rdata 0x80FF_1234, rvalid one cycle after gnt -> ld_data_o 0xFFFFFF80; LBU from the same address -> 0x00000080; 4-cycle latency.
- Half store: SH addr 0x0A, st_data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; gnt held off 3 cycles -> stall extends exactly 3 cycles and addr/be stay stable.
- Watchdog: WAIT_MAX = 4, LW with rvalid never asserted -> DONE after 4 WAIT cycles, err_o pulse, ld_data_o 0; a later rvalid is ignored.
- Reset mid-access: rst_i high while in WAIT -> next cycle IDLE, req 0, stall 0; a subsequent rvalid does not change ld_data_o (stays 0).
- Misalign: LW addr 0x102 -> with MEM_MISALIGN_TRAP_EN, no req and err_o = 1 after 1 stall cycle; without the macro, req addr 0x100, be 1111, err_o 0.
